// File: rtl/suspend_ack_ctrl.sv
// suspend_ack_ctrl: answers a synchronized suspend request by quiescing the fabric,
// draining it to idle (or timing out), acknowledging, and settling again on wake.
module suspend_ack_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 16,
    parameter int TIMEOUT     = 1024,
    parameter int WAKE_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SREQ,
    input  logic       BUSY,
    output logic       SACK,
    output logic       QUIESCE,
    output logic       SUSPENDED,
    output logic       TIMEOUT_FLAG,
    output logic [1:0] STATE
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int IW = IDLE_CYCLES > 1 ? $clog2(IDLE_CYCLES) : 1;
    localparam int WW = WAKE_CYCLES > 1 ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_MAX = WW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, ACK, WAKE} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic [IW-1:0]          idle_cnt;
    logic [TW-1:0]          tmo_cnt;
    logic [WW-1:0]          wake_cnt;
    logic                   sreq_s, idle_hit, tmo_hit;

    assign sreq_s   = sync[SYNC_STAGES-1];
    assign idle_hit = !BUSY && idle_cnt == IDLE_MAX;
    assign tmo_hit  = tmo_cnt == TMO_MAX;

    always_ff @(posedge CLK) begin
        if (!RST_N) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], SREQ};
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= RUN;
        else        state <= state_n;
    end

    // Withdrawal beats everything in DRAIN; idle beats timeout on a tie.
    always_comb begin
        state_n = state;
        case (state)
            RUN:   state_n = sreq_s ? DRAIN : RUN;
            DRAIN: state_n = !sreq_s ? RUN : (idle_hit || tmo_hit) ? ACK : DRAIN;
            ACK:   state_n = sreq_s ? ACK : WAKE;
            WAKE:  state_n = sreq_s ? DRAIN : wake_cnt == WAKE_MAX ? RUN : WAKE;
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            idle_cnt     <= '0;
            tmo_cnt      <= '0;
            wake_cnt     <= '0;
            TIMEOUT_FLAG <= 1'b0;
        end else begin
            if (state != DRAIN && state_n == DRAIN) begin
                idle_cnt     <= '0;
                tmo_cnt      <= '0;
                TIMEOUT_FLAG <= 1'b0;
            end else if (state == DRAIN) begin
                tmo_cnt  <= tmo_hit ? tmo_cnt : tmo_cnt + 1'b1;
                idle_cnt <= BUSY ? '0 : idle_cnt == IDLE_MAX ? idle_cnt : idle_cnt + 1'b1;
                if (state_n == ACK) TIMEOUT_FLAG <= !idle_hit;
            end
            wake_cnt <= state != WAKE ? '0 : wake_cnt == WAKE_MAX ? wake_cnt : wake_cnt + 1'b1;
        end
    end

    always_comb begin
        SACK      = state == ACK;
        SUSPENDED = state == ACK;
        QUIESCE   = state != RUN;
        STATE     = state;
    end
endmodule

// File: tb/tb_suspend_ack_ctrl.sv
// tb_suspend_ack_ctrl: directed scenarios then random traffic against a cycle-level
// behavioural model of the suspend handshake.
module tb_suspend_ack_ctrl;
    localparam int SYNC  = 2;
    localparam int IDLE  = 16;
    localparam int TMO   = 64;
    localparam int WAKEC = 8;

    logic       clk = 1'b0, rst_n = 1'b0, sreq = 1'b0, busy = 1'b0;
    logic       sack, quiesce, suspended, tflag;
    logic [1:0] state;
    int         npass = 0, ntotal = 0;

    int m_mode = 0, m_idle = 0, m_age = 0, m_wake = 0;
    bit m_flag = 0;
    bit sreq_log[$];

    suspend_ack_ctrl #(
        .SYNC_STAGES(SYNC), .IDLE_CYCLES(IDLE), .TIMEOUT(TMO), .WAKE_CYCLES(WAKEC)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .SREQ(sreq), .BUSY(busy),
        .SACK(sack), .QUIESCE(quiesce), .SUSPENDED(suspended),
        .TIMEOUT_FLAG(tflag), .STATE(state)
    );

    always #5 clk = ~clk;

    // Request as seen by the controller: the SREQ sampled SYNC-1 edges ago.
    function automatic bit sreq_seen();
        return sreq_log.size() >= SYNC ? sreq_log[sreq_log.size() - SYNC] : 1'b0;
    endfunction

    task automatic enter_drain();
        m_mode = 1;
        m_idle = 0;
        m_age  = 0;
        m_flag = 0;
    endtask

    task automatic model_step();
        bit s = sreq_seen();
        if (!rst_n) begin
            m_mode = 0; m_idle = 0; m_age = 0; m_wake = 0; m_flag = 0;
            sreq_log.delete();
            return;
        end
        case (m_mode)
            0: if (s) enter_drain();
            1: begin
                m_idle = busy ? 0 : m_idle + 1;
                m_age  = m_age + 1;
                if (!s) m_mode = 0;
                else if (m_idle >= IDLE) begin m_mode = 2; m_flag = 0; end
                else if (m_age >= TMO) begin m_mode = 2; m_flag = 1; end
            end
            2: if (!s) begin m_mode = 3; m_wake = 0; end
            default: begin
                if (s) enter_drain();
                else begin
                    m_wake = m_wake + 1;
                    if (m_wake >= WAKEC) m_mode = 0;
                end
            end
        endcase
        sreq_log.push_back(sreq);
        if (sreq_log.size() > 8) void'(sreq_log.pop_front());
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state", state, m_mode);
        chk("sack", sack, m_mode == 2);
        chk("suspended", suspended, m_mode == 2);
        chk("quiesce", quiesce, m_mode != 0);
        chk("tflag", tflag, m_flag);
    endtask

    initial begin
        int bias;
        repeat (2) tick();
        chk("reset_state", state, 0);
        chk("reset_sack", sack, 0);

        // basic suspend with the fabric idle
        rst_n = 1; sreq = 1; busy = 0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 2)  chk("basic_q_early", quiesce, 0);
            if (e == 3)  chk("basic_q_edge3", quiesce, 1);
            if (e == 18) chk("basic_sack_early", sack, 0);
            if (e == 19) begin
                chk("basic_sack_edge19", sack, 1);
                chk("basic_susp_edge19", suspended, 1);
                chk("basic_tflag", tflag, 0);
            end
        end

        // wake from ACK
        sreq = 0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 2)  chk("wake_sack_held", sack, 1);
            if (e == 3)  chk("wake_sack_drop", sack, 0);
            if (e == 10) chk("wake_still_quiesced", quiesce, 1);
            if (e == 11) chk("wake_to_run", state, 0);
        end

        // withdraw mid-drain
        sreq = 1; busy = 1;
        repeat (8) tick();
        sreq = 0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (e == 2) chk("withdraw_still_drain", state, 1);
            if (e == 3) chk("withdraw_run", state, 0);
        end

        // busy pulses restart the idle count
        sreq = 1;
        for (int e = 1; e <= 34; e++) begin
            busy = (e <= 5) || (e >= 16 && e <= 18);
            tick();
            if (e == 33) chk("busy_sack_early", sack, 0);
            if (e == 34) chk("busy_sack_rise", sack, 1);
        end
        sreq = 0;
        repeat (14) tick();

        // timeout, flag held through wake, re-suspend from WAKE clears it
        sreq = 1; busy = 1;
        for (int e = 1; e <= 67; e++) begin
            tick();
            if (e == 66) chk("tmo_sack_early", sack, 0);
            if (e == 67) begin
                chk("tmo_sack", sack, 1);
                chk("tmo_flag", tflag, 1);
            end
        end
        sreq = 0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            if (e == 5) begin
                chk("tmo_wake_state", state, 3);
                chk("tmo_flag_in_wake", tflag, 1);
                sreq = 1; busy = 0;
            end
            if (e == 8) begin
                chk("resuspend_drain", state, 1);
                chk("resuspend_flag_clr", tflag, 0);
            end
            if (e == 23) chk("resuspend_sack_early", sack, 0);
            if (e == 24) chk("resuspend_sack", sack, 1);
        end
        sreq = 0;
        repeat (14) tick();

        // idle and timeout coincide: idle wins
        sreq = 1;
        for (int e = 1; e <= 67; e++) begin
            busy = e <= 51;
            tick();
            if (e == 66) chk("tie_sack_early", sack, 0);
            if (e == 67) begin
                chk("tie_sack", sack, 1);
                chk("tie_flag", tflag, 0);
            end
        end
        sreq = 0;
        repeat (14) tick();

        // reset while acknowledged after a timeout
        sreq = 1; busy = 1;
        repeat (67) tick();
        chk("pre_rst_flag", tflag, 1);
        rst_n = 0;
        tick();
        chk("rst_sack", sack, 0);
        chk("rst_quiesce", quiesce, 0);
        chk("rst_susp", suspended, 0);
        chk("rst_flag", tflag, 0);
        chk("rst_state", state, 0);
        rst_n = 1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (e == 2) chk("post_rst_run", state, 0);
            if (e == 3) chk("post_rst_drain", state, 1);
        end

        // random traffic
        bias = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 256 == 0) bias = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(0, 90);
            if ($urandom_range(0, 99) == 0) sreq = ~sreq;
            busy  = $urandom_range(0, 99) < bias;
            rst_n = $urandom_range(0, 799) != 0;
            tick();
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
